// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO that feeds a uart one frame at a time over data_send/ena_tx.
// Define UART_TXQ_OVF_CNT_EN to add the saturating ovf_cnt output that counts dropped pushes.
module uart_tx_queue #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level,
    output logic             busy,
    output logic [7:0]       data_send,
    output logic             ena_tx,
    input  logic             tx_done
`ifdef UART_TXQ_OVF_CNT_EN
    ,
    output logic [7:0]       ovf_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t         state, state_nx;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  rptr, wptr;
    logic           push, pop;

    assign full  = level == CNT_W'(DEPTH);
    assign empty = level == '0;
    assign push  = wr_en && !full;
    assign pop   = state == IDLE && !empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wr_data;
    end

    // Pointers are AW bits wide, so they wrap at DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr      <= '0;
            wptr      <= '0;
            level     <= '0;
            data_send <= 8'h00;
            state     <= IDLE;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop) begin
                rptr      <= rptr + 1'b1;
                data_send <= mem[rptr];
            end
            level <= level + CNT_W'(push) - CNT_W'(pop);
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ena_tx   = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!empty)
                    state_nx = LOAD;
            end
            LOAD: begin
                ena_tx   = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                ena_tx = 1'b1;
                if (tx_done)
                    state_nx = GAP;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef UART_TXQ_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovf_cnt <= 8'h00;
        else if (wr_en && full && ovf_cnt != 8'hFF)
            ovf_cnt <= ovf_cnt + 8'h01;
    end
`endif
endmodule
